// File: rtl/adc_pkg.sv
// Shared ADC definitions: controller state encoding and the default ladder
// width, which the audio playback path also uses for its R2R output.
package adc_pkg;

  // Width of the 7-bit R2R ladder shared with the audio path
  localparam int ADC_WIDTH = 7;

  // Controller states: waiting for a request, or walking the binary search
  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } adc_state_t;

endpackage

// File: rtl/comp_sync.sv
// Two-flop synchronizer for an asynchronous single-bit pin such as the
// external comparator output or a button.
module comp_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the pin, then let any metastability resolve in a second flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_sar_adc.sv
// Successive-approximation controller that reuses the audio R2R ladder as the
// trial DAC and an external comparator to digitise the paddle or line level.
// Each bit is held on the ladder for SETTLE_CYCLES clocks before the
// synchronized comparator decides whether that bit stays set.
module paddle_sar_adc
  import adc_pkg::*;
#(
  parameter int WIDTH         = ADC_WIDTH,
  parameter int SETTLE_CYCLES = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             comp_in,
  output logic [WIDTH-1:0] r2r,
  output logic [WIDTH-1:0] sample,
  output logic             valid,
  output logic             busy
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] MSB_CODE   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    SETTLE_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]    TOP_INDEX  = IW'(WIDTH - 1);

  adc_state_t       state;
  logic [CW-1:0]    settle_cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] decided;
  logic             comp_s;

  comp_sync u_comp_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (comp_in),
    .q       (comp_s)
  );

  // Result after resolving the current trial bit: kept when Vin >= Vdac
  always_comb begin
    decided = result;
    if (comp_s) begin
      decided = result | trial;
    end
  end

  // Conversion FSM with settle counter, bit index, trial/result registers
  // and registered ladder, sample, valid and busy outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      bit_idx    <= '0;
      trial      <= '0;
      result     <= '0;
      r2r        <= '0;
      sample     <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            trial      <= MSB_CODE;
            result     <= '0;
            bit_idx    <= TOP_INDEX;
            settle_cnt <= '0;
            r2r        <= MSB_CODE;
            busy       <= 1'b1;
            state      <= CONVERT;
          end
        end

        CONVERT: begin
          if (settle_cnt == SETTLE_END) begin
            result <= decided;
            if (bit_idx != '0) begin
              trial      <= trial >> 1;
              r2r        <= decided | (trial >> 1);
              bit_idx    <= bit_idx - IW'(1);
              settle_cnt <= '0;
            end else begin
              trial  <= '0;
              r2r    <= decided;
              sample <= decided;
              valid  <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_sar_adc.sv
// Scoreboard bench for paddle_sar_adc: stimulus pushes the input level of
// every accepted conversion, a monitor checks the ladder walk, timing and
// result against a binary-search model whenever the DUT converts.
module tb_paddle_sar_adc;

  localparam int W    = 7;
  localparam int S    = 4;
  localparam int CONV = W * S;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] vin_code;
  logic         comp_in;
  logic [W-1:0] r2r;
  logic [W-1:0] sample;
  logic         valid;
  logic         busy;

  int           checks = 0;
  int           passes = 0;
  int           cycle = 0;
  int           conv_start = 0;
  int           busy_cnt = 0;
  int           valid_count = 0;
  int           off;
  bit           in_conv = 1'b0;
  logic         prev_valid = 1'b0;
  logic         start_seen = 1'b0;
  logic [W-1:0] last_sample = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] popped;

  paddle_sar_adc #(
    .WIDTH         (W),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .comp_in (comp_in),
    .r2r     (r2r),
    .sample  (sample),
    .valid   (valid),
    .busy    (busy)
  );

  // Behavioural comparator: Vin >= Vdac
  assign comp_in = (vin_code >= r2r);

  always #5 clk = ~clk;

  // Code on the ladder while bit k of the search is being tried
  function automatic logic [W-1:0] model_walk(input logic [W-1:0] vin, input int k);
    int acc = 0;
    int code;
    for (int b = W - 1; b > W - 1 - k; b--) begin
      code = acc + (1 << b);
      if (int'(vin) >= code) acc = code;
    end
    return W'(acc + (1 << (W - 1 - k)));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycle);
  endtask

  task automatic flagFail(input string name, input int actual);
    checks++;
    $display("[TB] FAIL %s: got 0x%0h, expected no activity at cycle %0d", name, actual, cycle);
  endtask

  // Start value the DUT sees on each active edge
  always @(posedge clk) start_seen = start;

  // Monitor: checks ladder walk, latency, busy length and result per conversion
  always @(negedge clk) begin
    cycle++;
    if (!reset_n) begin
      in_conv     = 1'b0;
      prev_valid  = 1'b0;
      last_sample = '0;
    end else begin
      if (prev_valid) begin
        checkOutput("restart_on_start", int'(busy), int'(start_seen));
        checkOutput("valid_one_cycle", int'(valid), 0);
      end
      if (busy && !in_conv) begin
        in_conv    = 1'b1;
        conv_start = cycle;
        busy_cnt   = 0;
      end
      if (busy) begin
        off = cycle - conv_start;
        busy_cnt++;
        if ((off % S) == 0 && off < CONV) begin
          if (exp_q.size() == 0) flagFail("unexpected_conversion", int'(r2r));
          else checkOutput($sformatf("walk_bit%0d", off / S), int'(r2r), int'(model_walk(exp_q[0], off / S)));
        end
      end
      if (valid) begin
        if (exp_q.size() == 0) begin
          flagFail("unexpected_valid", int'(sample));
        end else begin
          popped = exp_q.pop_front();
          checkOutput("sample", int'(sample), int'(popped));
          checkOutput("latency", cycle - conv_start, CONV);
          checkOutput("busy_len", busy_cnt, CONV);
          checkOutput("busy_low_at_valid", int'(busy), 0);
          checkOutput("r2r_eq_sample", int'(r2r), int'(sample));
        end
        in_conv     = 1'b0;
        last_sample = sample;
        valid_count++;
      end else begin
        checkOutput("sample_stable", int'(sample), int'(last_sample));
      end
      prev_valid = valid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) flagFail("idle_timeout", int'(busy));
  endtask

  // Issue one accepted conversion at level v and record its expectation
  task automatic applyStimulus(input logic [W-1:0] v);
    wait_idle();
    vin_code = v;
    start    = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    int gap;
    reset_n  = 1'b0;
    start    = 1'b0;
    vin_code = '0;
    #12;
    checkOutput("reset_r2r", int'(r2r), 0);
    checkOutput("reset_sample", int'(sample), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single conversion with the documented ladder walk
    applyStimulus(7'h55);
    drain();

    // Full-scale then zero-scale
    applyStimulus(7'h7F);
    applyStimulus(7'h00);
    drain();
    checkOutput("r2r_after_zero", int'(r2r), 0);

    // Start held high: three back-to-back conversions
    vin_code = 7'h2A;
    repeat (3) exp_q.push_back(7'h2A);
    base  = valid_count;
    start = 1'b1;
    n = 0;
    while (valid_count < base + 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    checkOutput("held_valids", valid_count - base, 3);
    drain();

    // Start pulses during a conversion are ignored
    applyStimulus(7'h19);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Reset partway through a conversion
    applyStimulus(7'h33);
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_r2r", int'(r2r), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_sample", int'(sample), 0);
    checkOutput("abort_valid", int'(valid), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(7'h4B);
    drain();

    // Level changes between conversions
    applyStimulus(7'h10);
    applyStimulus(7'h70);
    drain();

    // Randomized levels with random gaps (zero gap restarts in the valid cycle)
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      gap = $urandom_range(3, 0);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(W'($urandom_range(127, 0)));
    end
    drain();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/paddle_sar_adc.md
# paddle_sar_adc

Successive-approximation ADC controller that reads an analog level (paddle potentiometer or audio line) through the same 7-bit R2R ladder plus an external comparator. The audio playback path drives the ladder as an output; this block drives it as the DAC inside a conversion loop and returns a digital code. It sits between the board-level ladder/comparator pins and the game logic that consumes paddle position.

## Interface
- WIDTH, 7: ladder and result width in bits.
- SETTLE_CYCLES, 50: clocks each trial code is held before the comparator is sampled; must be ≥ 3.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only when idle.
- comp_in  input  1  asynchronous comparator output; 1 means Vin ≥ Vdac.
- r2r  output  WIDTH  trial code driven onto the ladder.
- sample  output  WIDTH  last completed conversion result.
- valid  output  1  one-cycle pulse when sample updates.
- busy  output  1  conversion in progress.

## Operation
- comp_in passes through a 2-flop synchronizer before any use.
- States: IDLE, CONVERT.
- IDLE: busy=0; r2r holds the last result. On start=1: load trial = MSB only (1000000 for WIDTH=7), clear the working result, bit index = WIDTH-1, settle counter = 0, go to CONVERT.
- CONVERT: busy=1; r2r = working result | current trial bit. The counter increments each cycle. When it reaches SETTLE_CYCLES-1, that edge:
  - keeps the trial bit if synchronized comp = 1, else clears it;
  - if bit index > 0: moves the trial bit one place right, clears the counter, stays in CONVERT;
  - if bit index = 0: writes the final code to sample, pulses valid, returns to IDLE.
- start while busy is ignored and not queued.
- The conversion is monotonic binary search; the result equals floor(Vin code) under the Vin ≥ Vdac comparator convention.
- Reset mid-conversion aborts it: all state returns to reset values and no valid is issued.

## Timing
- Reset values: r2r=0, sample=0, valid=0, busy=0, state IDLE, synchronizer flops 0.
- Start edge T0: r2r = MSB trial and busy=1, both visible after T0.
- Each bit occupies exactly SETTLE_CYCLES cycles. The comparator value used is the synchronizer output on the deciding edge, which reflects comp_in about 2 cycles earlier; SETTLE_CYCLES ≥ 3 guarantees the ladder has settled.
- Completion: valid=1, the new sample value, and busy=0 appear together, WIDTH×SETTLE_CYCLES cycles after T0.
  - valid is high for exactly one cycle.
  - r2r equals sample from that cycle on.
- Back-to-back: start=1 during the valid cycle is accepted. The next conversion begins on that edge, so there is a minimum of zero idle cycles between conversions.
- sample is stable between valid pulses.

## Structure
- Shared package adc_pkg:
  - adc_state_t enum {IDLE, CONVERT};
  - default width constant ADC_WIDTH = 7, shared with the audio path's ladder width.
- Sub-module comp_sync: 2-flop synchronizer (clk, reset_n, d, q). Reusable for other pin inputs such as buttons.
- One FSM plus the settle counter, bit-index register, trial register and result register live in the top module.

## Test plan
All scenarios use SETTLE_CYCLES=4 and a behavioural comparator: comp_in = (vin_code ≥ r2r), updated combinationally.
- vin_code=0x55, single start pulse:
  - r2r walks 0x40, 0x60, 0x50, 0x58, 0x54, 0x56, 0x55;
  - valid pulses exactly 28 cycles after the start edge with sample=0x55;
  - busy is high for 28 cycles.
- vin_code=0x7F, then vin_code=0x00 → sample=0x7F, then sample=0x00. r2r=0 after the second conversion.
- start held high continuously with vin_code=0x2A → valid every 28 cycles, each with sample=0x2A, with no idle gap. Extra start pulses mid-conversion are ignored (no extra valid).
- Asserting reset_n=0 at cycle 10 of a conversion:
  - r2r, busy and sample clear immediately;
  - no valid is issued;
  - a new start after release converts normally.
- vin_code changes from 0x10 to 0x70 between conversions → sample=0x10, then 0x70. sample holds 0x10 through the entire second conversion until its valid.
